// File: rtl/vend_ctrl.sv
// vend_ctrl: session sequencer for the vending change/dispense datapath.
// Collects coins up to a signed-safe credit cap, latches a selection, checks
// funds on confirm, then runs dispense/change or refund ready/valid handshakes.
module vend_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_valid,
    input  logic [DW-1:0] coin_value,
    output logic          coin_reject,
    input  logic          sel_valid,
    input  logic [DW-1:0] sel_price,
    input  logic [DW-1:0] sel_count,
    input  logic          confirm,
    input  logic          cancel,
    output logic [DW-1:0] total_insert,
    output logic          dispense_valid,
    output logic [DW-1:0] dispense_count,
    input  logic          dispense_ready,
    output logic          change_valid,
    output logic [DW-1:0] change_price,
    input  logic          change_ready,
    output logic          short,
    output logic          busy
);

    // Credit is capped so its top bit is always clear.
    localparam int                CAP_INT = (1 << (DW - 1)) - 1;
    localparam logic [DW:0]       CAP_W   = (DW + 1)'(CAP_INT);
    localparam logic [2*DW-1:0]   CAP_2W  = (2 * DW)'(CAP_INT);
    // Timer only needs to count 0 .. TIMEOUT-1.
    localparam int                TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TMAX    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   credit_reg, credit_next;
    logic [DW-1:0]   price_reg, price_next;
    logic [DW-1:0]   count_reg, count_next;
    logic            sel_have_reg, sel_have_next;
    logic [2*DW-1:0] total_reg, total_next;
    logic [DW-1:0]   amount_reg, amount_next;
    logic [TW-1:0]   timer_reg, timer_next;

    logic            coin_reject_reg, coin_reject_next;
    logic            dispense_valid_reg, dispense_valid_next;
    logic [DW-1:0]   dispense_count_reg, dispense_count_next;
    logic            change_valid_reg, change_valid_next;
    logic [DW-1:0]   change_price_reg, change_price_next;
    logic            short_reg, short_next;
    logic            busy_reg, busy_next;

    logic [DW:0]     coin_sum;
    logic            coin_fits;
    logic            coin_accept;
    logic            funds_ok;

    assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_value};
    assign coin_fits = (coin_sum <= CAP_W);
    // Overflowed totals exceed the cap and therefore any possible credit too.
    assign funds_ok  = (total_reg <= {{DW{1'b0}}, credit_reg}) && (total_reg <= CAP_2W);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        price_next    = price_reg;
        count_next    = count_reg;
        sel_have_next = sel_have_reg;
        total_next    = total_reg;
        amount_next   = amount_reg;
        timer_next    = timer_reg;
        coin_accept   = 1'b0;
        short_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (sel_valid) begin
                    price_next    = sel_price;
                    count_next    = sel_count;
                    sel_have_next = 1'b1;
                end
                if (coin_valid && coin_fits) begin
                    coin_accept = 1'b1;
                    credit_next = coin_sum[DW-1:0];
                    timer_next  = '0;
                    state_next  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    amount_next = credit_reg;
                    state_next  = (credit_reg != '0) ? S_REFUND : S_IDLE;
                end else if (confirm && sel_have_reg) begin
                    total_next = {{DW{1'b0}}, price_reg} * {{DW{1'b0}}, count_reg};
                    state_next = S_CHECK;
                end else begin
                    if (sel_valid) begin
                        price_next    = sel_price;
                        count_next    = sel_count;
                        sel_have_next = 1'b1;
                    end
                    if (coin_valid && coin_fits) begin
                        coin_accept = 1'b1;
                        credit_next = coin_sum[DW-1:0];
                    end
                    if (coin_valid || sel_valid) begin
                        timer_next = '0;
                    end else if (timer_reg == TMAX) begin
                        amount_next = credit_reg;
                        state_next  = (credit_reg != '0) ? S_REFUND : S_IDLE;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end

            S_CHECK: begin
                if (funds_ok) begin
                    if (count_reg == '0) begin
                        amount_next = credit_reg;
                        state_next  = (credit_reg != '0) ? S_CHANGE : S_IDLE;
                    end else begin
                        amount_next = credit_reg - total_reg[DW-1:0];
                        state_next  = S_DISPENSE;
                    end
                end else begin
                    short_next  = 1'b1;
                    amount_next = credit_reg;
                    state_next  = (credit_reg != '0) ? S_REFUND : S_IDLE;
                end
            end

            S_DISPENSE: begin
                if (dispense_ready) begin
                    state_next = (amount_reg != '0) ? S_CHANGE : S_IDLE;
                end
            end

            S_CHANGE, S_REFUND: begin
                if (change_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase

        // Ending a session wipes everything it accumulated.
        if (state_reg != S_IDLE && state_next == S_IDLE) begin
            credit_next   = '0;
            price_next    = '0;
            count_next    = '0;
            sel_have_next = 1'b0;
            total_next    = '0;
            amount_next   = '0;
            timer_next    = '0;
        end

        coin_reject_next    = coin_valid && !coin_accept;
        dispense_valid_next = (state_next == S_DISPENSE);
        dispense_count_next = (state_next == S_DISPENSE) ? count_next : '0;
        change_valid_next   = (state_next == S_CHANGE) || (state_next == S_REFUND);
        change_price_next   = change_valid_next ? amount_next : '0;
        busy_next           = (state_next != S_IDLE) && (state_next != S_COLLECT);
    end

    // State, datapath and output registers; reset abandons the session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            credit_reg         <= '0;
            price_reg          <= '0;
            count_reg          <= '0;
            sel_have_reg       <= 1'b0;
            total_reg          <= '0;
            amount_reg         <= '0;
            timer_reg          <= '0;
            coin_reject_reg    <= 1'b0;
            dispense_valid_reg <= 1'b0;
            dispense_count_reg <= '0;
            change_valid_reg   <= 1'b0;
            change_price_reg   <= '0;
            short_reg          <= 1'b0;
            busy_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            credit_reg         <= credit_next;
            price_reg          <= price_next;
            count_reg          <= count_next;
            sel_have_reg       <= sel_have_next;
            total_reg          <= total_next;
            amount_reg         <= amount_next;
            timer_reg          <= timer_next;
            coin_reject_reg    <= coin_reject_next;
            dispense_valid_reg <= dispense_valid_next;
            dispense_count_reg <= dispense_count_next;
            change_valid_reg   <= change_valid_next;
            change_price_reg   <= change_price_next;
            short_reg          <= short_next;
            busy_reg           <= busy_next;
        end
    end

    assign coin_reject    = coin_reject_reg;
    assign total_insert   = credit_reg;
    assign dispense_valid = dispense_valid_reg;
    assign dispense_count = dispense_count_reg;
    assign change_valid   = change_valid_reg;
    assign change_price   = change_price_reg;
    assign short          = short_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed sessions for vend_ctrl with hand-computed expectations.
module tb_vend_ctrl;

    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_valid;
    logic [DW-1:0] coin_value;
    logic          coin_reject;
    logic          sel_valid;
    logic [DW-1:0] sel_price;
    logic [DW-1:0] sel_count;
    logic          confirm;
    logic          cancel;
    logic [DW-1:0] total_insert;
    logic          dispense_valid;
    logic [DW-1:0] dispense_count;
    logic          dispense_ready;
    logic          change_valid;
    logic [DW-1:0] change_price;
    logic          change_ready;
    logic          short;
    logic          busy;

    int errors = 0;
    int checks = 0;

    vend_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .coin_reject    (coin_reject),
        .sel_valid      (sel_valid),
        .sel_price      (sel_price),
        .sel_count      (sel_count),
        .confirm        (confirm),
        .cancel         (cancel),
        .total_insert   (total_insert),
        .dispense_valid (dispense_valid),
        .dispense_count (dispense_count),
        .dispense_ready (dispense_ready),
        .change_valid   (change_valid),
        .change_price   (change_price),
        .change_ready   (change_ready),
        .short          (short),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [DW-1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = '0;
        $display("coin %0d -> total_insert=%0d reject=%0d", v, total_insert, coin_reject);
    endtask

    task automatic sel(input logic [DW-1:0] p, input logic [DW-1:0] c);
        sel_valid = 1'b1;
        sel_price = p;
        sel_count = c;
        tick();
        sel_valid = 1'b0;
        $display("select %0d x %0d", p, c);
    endtask

    task automatic do_confirm();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        $display("confirm -> busy=%0d", busy);
    endtask

    initial begin
        rst_n          = 1'b0;
        coin_valid     = 1'b0;
        coin_value     = '0;
        sel_valid      = 1'b0;
        sel_price      = '0;
        sel_count      = '0;
        confirm        = 1'b0;
        cancel         = 1'b0;
        dispense_ready = 1'b1;
        change_ready   = 1'b1;

        tick();
        tick();
        chk("reset_total", total_insert, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dv", dispense_valid, 0);
        chk("reset_cv", change_valid, 0);
        rst_n = 1'b1;
        tick();

        // Session 1: 100 credit, 30x2 -> dispense 2, change 40.
        coin(50);
        coin(50);
        chk("s1_total", total_insert, 100);
        sel(30, 2);
        do_confirm();
        chk("s1_check_busy", busy, 1);
        chk("s1_check_dv", dispense_valid, 0);
        tick();
        $display("s1 dispense_valid=%0d count=%0d", dispense_valid, dispense_count);
        chk("s1_dv", dispense_valid, 1);
        chk("s1_dcount", dispense_count, 2);
        tick();
        $display("s1 change_valid=%0d price=%0d", change_valid, change_price);
        chk("s1_dv_done", dispense_valid, 0);
        chk("s1_cv", change_valid, 1);
        chk("s1_cprice", change_price, 40);
        tick();
        chk("s1_idle_cv", change_valid, 0);
        chk("s1_idle_total", total_insert, 0);
        chk("s1_idle_busy", busy, 0);

        // Session 2: 20 credit, 15x2 = 30 -> short, refund 20.
        coin(20);
        sel(15, 2);
        do_confirm();
        tick();
        $display("s2 short=%0d change_valid=%0d price=%0d", short, change_valid, change_price);
        chk("s2_short", short, 1);
        chk("s2_dv", dispense_valid, 0);
        chk("s2_cv", change_valid, 1);
        chk("s2_cprice", change_price, 20);
        tick();
        chk("s2_short_end", short, 0);
        chk("s2_idle_cv", change_valid, 0);
        chk("s2_idle_total", total_insert, 0);

        // Session 3: exact payment -> dispense 1, no change handshake.
        coin(25);
        sel(25, 1);
        do_confirm();
        tick();
        $display("s3 dispense_valid=%0d count=%0d", dispense_valid, dispense_count);
        chk("s3_dv", dispense_valid, 1);
        chk("s3_dcount", dispense_count, 1);
        chk("s3_cv_a", change_valid, 0);
        tick();
        chk("s3_cv_b", change_valid, 0);
        chk("s3_dv_done", dispense_valid, 0);
        chk("s3_busy", busy, 0);

        // Session 4: over-cap coin rejected; 20x10 = 200 overflows -> refund 100.
        coin(100);
        chk("s4_first_reject", coin_reject, 0);
        coin(50);
        chk("s4_reject", coin_reject, 1);
        chk("s4_total", total_insert, 100);
        tick();
        chk("s4_reject_end", coin_reject, 0);
        sel(20, 10);
        do_confirm();
        tick();
        $display("s4 short=%0d change_valid=%0d price=%0d", short, change_valid, change_price);
        chk("s4_short", short, 1);
        chk("s4_cprice", change_price, 100);
        tick();
        chk("s4_idle_total", total_insert, 0);

        // Session 5: cancel wins over same-cycle coin; refund held with ready low.
        change_ready = 1'b0;
        coin(70);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 5;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin_value = '0;
        $display("s5 cancel reject=%0d change_valid=%0d price=%0d", coin_reject, change_valid, change_price);
        chk("s5_reject", coin_reject, 1);
        chk("s5_cv", change_valid, 1);
        chk("s5_cprice", change_price, 70);
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("s5 hold %0d change_valid=%0d price=%0d", i, change_valid, change_price);
            chk("s5_hold_cv", change_valid, 1);
            chk("s5_hold_price", change_price, 70);
        end
        change_ready = 1'b1;
        tick();
        chk("s5_idle_cv", change_valid, 0);

        // Session 6: timeout after TIMEOUT idle cycles -> refund 10.
        coin(10);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("s6_before_to", change_valid, 0);
        tick();
        $display("s6 timeout change_valid=%0d price=%0d", change_valid, change_price);
        chk("s6_to_cv", change_valid, 1);
        chk("s6_to_price", change_price, 10);
        tick();
        chk("s6_idle_total", total_insert, 0);

        // Session 7: reset asserted mid-dispense clears outputs at once.
        dispense_ready = 1'b0;
        coin(30);
        sel(10, 1);
        do_confirm();
        tick();
        chk("s7_dv", dispense_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("s7 reset dispense_valid=%0d busy=%0d total=%0d", dispense_valid, busy, total_insert);
        chk("s7_rst_dv", dispense_valid, 0);
        chk("s7_rst_dcount", dispense_count, 0);
        chk("s7_rst_busy", busy, 0);
        chk("s7_rst_total", total_insert, 0);
        tick();
        rst_n = 1'b1;
        dispense_ready = 1'b1;
        tick();
        chk("s7_post_busy", busy, 0);
        coin(5);
        chk("s7_post_total", total_insert, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
